// File: rtl/io_bus_pkg.sv
// Shared definitions for the s1c88 I/O register page: CPU bus commands,
// router FSM states and page geometry.
package io_bus_pkg;

  // Mirrors the CPU's bus_status encoding.
  typedef enum logic [1:0] {
    BUS_IDLE      = 2'd0,
    BUS_IRQ_READ  = 2'd1,
    BUS_MEM_WRITE = 2'd2,
    BUS_MEM_READ  = 2'd3
  } bus_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_HOLD     = 2'd2
  } io_state_e;

  localparam int IO_PAGE_SIZE = 256;
  localparam int OFFSET_W     = $clog2(IO_PAGE_SIZE);

  // Slave index width; a single slave still needs a one-bit index.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_addr_decode.sv
// Page offset to slave priority decoder; the lowest-index owner wins on overlap.
module io_addr_decode
  import io_bus_pkg::*;
#(
  parameter int                      NUM_SLAVES = 4,
  parameter int                      SEL_W      = sel_width(NUM_SLAVES),
  parameter logic [NUM_SLAVES*8-1:0] SLAVE_LO   = '0,
  parameter logic [NUM_SLAVES*8-1:0] SLAVE_HI   = '1
) (
  input  logic [OFFSET_W-1:0] offset_i,
  output logic                hit_o,
  output logic [SEL_W-1:0]    sel_o
);

  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    // Descending scan so the lowest matching index is the last one written.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (offset_i >= SLAVE_LO[8*i +: 8] && offset_i <= SLAVE_HI[8*i +: 8]) begin
        hit_o = 1'b1;
        sel_o = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/io_reg_router.sv
// I/O page router: decodes CPU accesses into one-cycle slave strobes,
// waits for read acks with timeout, and passes non-I/O reads through.
//   state    | meaning
//   IDLE     | waiting for a qualified read/write rising edge
//   WAIT_ACK | read strobed, waiting for the selected slave's ack
//   HOLD     | access finished, waiting for cpu_read and cpu_write to drop
module io_reg_router
  import io_bus_pkg::*;
#(
  parameter int                      NUM_SLAVES     = 4,
  parameter int                      ADDR_W         = 24,
  parameter logic [ADDR_W-1:0]       IO_BASE        = 24'h2000,
  parameter logic [NUM_SLAVES*8-1:0] SLAVE_LO       = 32'hC0_80_40_00,
  parameter logic [NUM_SLAVES*8-1:0] SLAVE_HI       = 32'hFF_BF_7F_3F,
  parameter logic [7:0]              UNMAPPED_VALUE = 8'hFF,
  parameter int                      TIMEOUT        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       cpu_address,
  input  logic [1:0]              cpu_bus_status,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [7:0]              cpu_data_out,
  input  logic [7:0]              ext_data_in,
  output logic [7:0]              cpu_data_in,
  output logic [NUM_SLAVES-1:0]   slv_rd_stb,
  output logic [NUM_SLAVES-1:0]   slv_wr_stb,
  output logic [7:0]              slv_offset,
  output logic [7:0]              slv_wdata,
  input  logic [NUM_SLAVES*8-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]   slv_ack,
  output logic                    err_unmapped,
  output logic                    err_timeout,
  output logic                    busy
);

  localparam int SEL_W = sel_width(NUM_SLAVES);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  io_state_e             state_q, state_d;
  logic                  rd_prev_q, wr_prev_q;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            data_q, data_d;
  logic [7:0]            offset_q, offset_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [NUM_SLAVES-1:0] rd_stb_q, rd_stb_d;
  logic [NUM_SLAVES-1:0] wr_stb_q, wr_stb_d;
  logic                  err_unm_q, err_unm_d;
  logic                  hold_rd_q, hold_rd_d;

  logic                  io_hit, dec_hit;
  logic [SEL_W-1:0]      dec_sel;
  logic                  rd_start, wr_start;
  logic                  ack_hit, timeout_hit;

  io_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W),
    .SLAVE_LO   (SLAVE_LO),
    .SLAVE_HI   (SLAVE_HI)
  ) u_decode (
    .offset_i (cpu_address[OFFSET_W-1:0]),
    .hit_o    (dec_hit),
    .sel_o    (dec_sel)
  );

  assign io_hit   = (cpu_address[ADDR_W-1:OFFSET_W] == IO_BASE[ADDR_W-1:OFFSET_W]);
  assign rd_start = cpu_read  & ~rd_prev_q & (cpu_bus_status == BUS_MEM_READ);
  assign wr_start = cpu_write & ~wr_prev_q & (cpu_bus_status == BUS_MEM_WRITE);

  // The first WAIT_ACK cycle is the strobe cycle; an ack there is too early.
  assign ack_hit     = (state_q == ST_WAIT_ACK) && slv_ack[sel_q] && (cnt_q != '0);
  assign timeout_hit = (state_q == ST_WAIT_ACK) && !ack_hit &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    offset_d  = offset_q;
    wdata_d   = wdata_q;
    rd_stb_d  = '0;
    wr_stb_d  = '0;
    err_unm_d = 1'b0;
    hold_rd_d = hold_rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          if (io_hit) begin
            hold_rd_d = 1'b1;
            if (dec_hit) begin
              rd_stb_d = NUM_SLAVES'(1) << dec_sel;
              sel_d    = dec_sel;
              offset_d = cpu_address[7:0];
              cnt_d    = '0;
              state_d  = ST_WAIT_ACK;
            end else begin
              data_d    = UNMAPPED_VALUE;
              err_unm_d = 1'b1;
              state_d   = ST_HOLD;
            end
          end
        end else if (wr_start && io_hit) begin
          hold_rd_d = 1'b0;
          if (dec_hit) begin
            wr_stb_d = NUM_SLAVES'(1) << dec_sel;
            offset_d = cpu_address[7:0];
            wdata_d  = cpu_data_out;
          end else begin
            err_unm_d = 1'b1;
          end
          state_d = ST_HOLD;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_hit) begin
          data_d  = slv_rdata[{sel_q, 3'b000} +: 8];
          state_d = ST_HOLD;
        end else if (timeout_hit) begin
          data_d  = UNMAPPED_VALUE;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!cpu_read && !cpu_write) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
      sel_q     <= '0;
      cnt_q     <= '0;
      data_q    <= UNMAPPED_VALUE;
      offset_q  <= 8'h00;
      wdata_q   <= 8'h00;
      rd_stb_q  <= '0;
      wr_stb_q  <= '0;
      err_unm_q <= 1'b0;
      hold_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_prev_q <= cpu_read;
      wr_prev_q <= cpu_write;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      offset_q  <= offset_d;
      wdata_q   <= wdata_d;
      rd_stb_q  <= rd_stb_d;
      wr_stb_q  <= wr_stb_d;
      err_unm_q <= err_unm_d;
      hold_rd_q <= hold_rd_d;
    end
  end

  always_comb begin
    cpu_data_in = ext_data_in;
    if (state_q == ST_WAIT_ACK)                cpu_data_in = UNMAPPED_VALUE;
    else if (state_q == ST_HOLD && hold_rd_q)  cpu_data_in = data_q;
  end

  assign slv_rd_stb   = rd_stb_q;
  assign slv_wr_stb   = wr_stb_q;
  assign slv_offset   = offset_q;
  assign slv_wdata    = wdata_q;
  assign err_unmapped = err_unm_q;
  assign err_timeout  = timeout_hit;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_io_reg_router.sv
// Randomized bench for io_reg_router: two slaves (0x00-0x7F, 0x80-0x8A),
// reactive slave models and a per-access outcome model.
module tb_io_reg_router;

  localparam int         NS  = 2;
  localparam int         TO  = 8;
  localparam logic [7:0] UNM = 8'hFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] cpu_address;
  logic [1:0]  cpu_bus_status;
  logic        cpu_read, cpu_write;
  logic [7:0]  cpu_data_out, ext_data_in, cpu_data_in;
  logic [1:0]  slv_rd_stb, slv_wr_stb;
  logic [7:0]  slv_offset, slv_wdata;
  logic [15:0] slv_rdata = '0;
  logic [1:0]  slv_ack = '0;
  logic        err_unmapped, err_timeout, busy;

  io_reg_router #(
    .NUM_SLAVES     (NS),
    .ADDR_W         (24),
    .IO_BASE        (24'h2000),
    .SLAVE_LO       (16'h80_00),
    .SLAVE_HI       (16'h8A_7F),
    .UNMAPPED_VALUE (UNM),
    .TIMEOUT        (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_address    (cpu_address),
    .cpu_bus_status (cpu_bus_status),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_data_out   (cpu_data_out),
    .ext_data_in    (ext_data_in),
    .cpu_data_in    (cpu_data_in),
    .slv_rd_stb     (slv_rd_stb),
    .slv_wr_stb     (slv_wr_stb),
    .slv_offset     (slv_offset),
    .slv_wdata      (slv_wdata),
    .slv_rdata      (slv_rdata),
    .slv_ack        (slv_ack),
    .err_unmapped   (err_unmapped),
    .err_timeout    (err_timeout),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled mid-cycle.
  int cyc = 0;
  int rd_pulses[2] = '{0, 0};
  int wr_pulses[2] = '{0, 0};
  int unm_pulses = 0, to_pulses = 0;
  int last_stb_cyc = 0, last_to_cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NS; i++) begin
      if (slv_rd_stb[i] === 1'b1) begin
        rd_pulses[i] <= rd_pulses[i] + 1;
        last_stb_cyc <= cyc;
      end
      if (slv_wr_stb[i] === 1'b1) wr_pulses[i] <= wr_pulses[i] + 1;
    end
    if (err_unmapped === 1'b1) unm_pulses <= unm_pulses + 1;
    if (err_timeout === 1'b1) begin
      to_pulses   <= to_pulses + 1;
      last_to_cyc <= cyc;
    end
  end

  // Slave model: ack sl_dly cycles after its strobe (0 = in the strobe cycle,
  // negative = never); optional spurious ack from the other slave.
  int         sl_dly  = -1;
  bit         sl_spur = 1'b0;
  logic [7:0] sl_val[2] = '{8'h00, 8'h00};
  int         cd[2] = '{0, 0};

  always @(posedge clk) begin
    logic [1:0] a;
    a = '0;
    #1;
    for (int i = 0; i < NS; i++) begin
      if (cd[i] > 0) begin
        cd[i] = cd[i] - 1;
        if (cd[i] == 0) a[i] = 1'b1;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (slv_rd_stb[i] === 1'b1) begin
        if (sl_dly == 0) a[i] = 1'b1;
        else if (sl_dly > 0) cd[i] = sl_dly;
        if (sl_spur) cd[1-i] = 1;
      end
    end
    slv_ack   <= a;
    slv_rdata <= {sl_val[1], sl_val[0]};
  end

  typedef struct {
    bit start_rd;
    bit start_wr;
    bit io;
    int sel;
    bit ack_ok;
  } pred_t;

  function automatic pred_t predict(input bit rd, input bit wr, input logic [1:0] st,
                                    input logic [23:0] addr, input int d);
    pred_t p;
    int off;
    int lo[2];
    int hi[2];
    lo = '{'h00, 'h80};
    hi = '{'h7F, 'h8A};
    off = int'(addr) % 256;
    p.start_rd = rd && (st == 2'd3);
    p.start_wr = wr && (st == 2'd2) && !p.start_rd;
    p.io       = (int'(addr) / 256) == ('h2000 / 256);
    p.sel      = -1;
    for (int i = 0; i < NS; i++)
      if (p.sel < 0 && off >= lo[i] && off <= hi[i]) p.sel = i;
    // Ack accepted from one cycle after the strobe up to the last waiting cycle.
    p.ack_ok = (d >= 1) && (d <= TO - 1);
    return p;
  endfunction

  logic [7:0] exp_off = 8'h00;
  logic [7:0] exp_wd  = 8'h00;

  task automatic run_access(input string nm, input bit rd, input bit wr, input logic [1:0] st,
                            input logic [23:0] addr, input logic [7:0] wd, input int d,
                            input bit sp, input int hold);
    pred_t      p;
    int         r0[2], w0[2];
    int         u0, t0, n;
    bit         io_rd, io_wr, mapped;
    logic [7:0] exp_data;
    p      = predict(rd, wr, st, addr, d);
    io_rd  = p.start_rd && p.io;
    io_wr  = p.start_wr && p.io;
    mapped = p.sel >= 0;
    sl_dly  = d;
    sl_spur = sp;
    sl_val[0] = 8'($urandom);
    sl_val[1] = 8'($urandom);
    exp_data = (mapped && p.ack_ok) ? sl_val[p.sel] : UNM;
    r0 = rd_pulses; w0 = wr_pulses; u0 = unm_pulses; t0 = to_pulses;

    @(negedge clk);
    cpu_address    = addr;
    cpu_bus_status = st;
    cpu_data_out   = wd;
    cpu_read       = rd;
    cpu_write      = wr;
    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      ext_data_in = 8'($urandom);
      #1;
      if (!io_rd) check_eq({nm, "/pass"}, cpu_data_in, ext_data_in);
      else if (j >= TO) check_eq({nm, "/hold_data"}, cpu_data_in, exp_data);
      if (!io_rd && !io_wr) check_eq({nm, "/busy0"}, busy, 0);
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq({nm, "/idle"}, busy, 0);

    for (int i = 0; i < NS; i++) begin
      check_eq({nm, "/rd_stb"}, rd_pulses[i] - r0[i], (io_rd && p.sel == i) ? 1 : 0);
      check_eq({nm, "/wr_stb"}, wr_pulses[i] - w0[i], (io_wr && p.sel == i) ? 1 : 0);
    end
    check_eq({nm, "/err_unm"}, unm_pulses - u0, ((io_rd || io_wr) && !mapped) ? 1 : 0);
    check_eq({nm, "/err_to"}, to_pulses - t0, (io_rd && mapped && !p.ack_ok) ? 1 : 0);
    if ((io_rd || io_wr) && mapped) exp_off = addr[7:0];
    if (io_wr && mapped) exp_wd = wd;
    check_eq({nm, "/offset"}, slv_offset, exp_off);
    check_eq({nm, "/wdata"}, slv_wdata, exp_wd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0[2];
    int t0, u0, mode, d, hold;
    logic [1:0]  st;
    logic [23:0] addr;

    reset = 1'b0;
    cpu_address = '0; cpu_bus_status = 2'd0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_data_out = '0; ext_data_in = 8'h5A;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst/busy", busy, 0);
    check_eq("rst/rd_stb", slv_rd_stb, 0);
    check_eq("rst/wr_stb", slv_wr_stb, 0);
    check_eq("rst/err_unm", err_unmapped, 0);
    check_eq("rst/err_to", err_timeout, 0);
    check_eq("rst/offset", slv_offset, 8'h00);
    check_eq("rst/wdata", slv_wdata, 8'h00);
    check_eq("rst/data", cpu_data_in, 8'h5A);
    reset = 1'b1;

    run_access("rd_2085",   1, 0, 2'd3, 24'h002085, 8'h00, 2, 0, 12);
    run_access("wr_2010",   0, 1, 2'd2, 24'h002010, 8'h3C, -1, 0, 5);
    run_access("rd_20c0",   1, 0, 2'd3, 24'h0020C0, 8'h00, 2, 0, 12);
    run_access("rd_tmo",    1, 0, 2'd3, 24'h002000, 8'h00, -1, 0, 12);
    check_eq("tmo_cycle", last_to_cyc - last_stb_cyc, TO - 1);
    run_access("rd_4000",   1, 0, 2'd3, 24'h004000, 8'h00, 2, 0, 8);
    run_access("ack_last",  1, 0, 2'd3, 24'h002040, 8'h00, TO - 1, 1, 12);
    run_access("ack_late",  1, 0, 2'd3, 24'h002081, 8'h00, TO, 0, 12);
    run_access("ack_early", 1, 0, 2'd3, 24'h002001, 8'h00, 0, 0, 12);
    run_access("drop_wait", 1, 0, 2'd3, 24'h002002, 8'h00, -1, 0, 2);
    run_access("wr_208b",   0, 1, 2'd2, 24'h00208B, 8'hA5, -1, 0, 4);
    run_access("rd_badst",  1, 0, 2'd0, 24'h002010, 8'h00, 2, 0, 6);

    // Reset in WAIT_ACK; the slave's ack lands after release.
    sl_dly = 6; sl_spur = 1'b0;
    @(negedge clk);
    cpu_address = 24'h002003; cpu_bus_status = 2'd3; cpu_read = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cpu_read = 1'b0;
    #1;
    check_eq("rstmid/busy", busy, 0);
    check_eq("rstmid/data", cpu_data_in, ext_data_in);
    r0 = rd_pulses; t0 = to_pulses; u0 = unm_pulses;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check_eq("rstmid/idle", busy, 0);
    check_eq("rstmid/to", to_pulses - t0, 0);
    check_eq("rstmid/unm", unm_pulses - u0, 0);
    check_eq("rstmid/stb", (rd_pulses[0] - r0[0]) + (rd_pulses[1] - r0[1]), 0);
    check_eq("rstmid/pass", cpu_data_in, ext_data_in);
    exp_off = 8'h00;
    exp_wd  = 8'h00;

    for (int k = 0; k < 50; k++) begin
      mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) st = 2'($urandom);
      else if (mode == 0) st = 2'd3;
      else if (mode == 1) st = 2'd2;
      else st = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd2;
      if ($urandom_range(0, 4) == 0) addr = 24'($urandom);
      else addr = {16'h0020, 8'($urandom)};
      d    = int'($urandom_range(0, 10)) - 1;
      hold = int'($urandom_range(10, 14));
      run_access("rand", mode != 1, mode != 0, st, addr, 8'($urandom), d,
                 $urandom_range(0, 1) == 1, hold);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
